// File: rtl/roce_tx_chan_arbiter.sv
// Multi-channel RoCE TX front end: round-robin meta arbitration into a one-entry output register,
// with payload steered combinationally from the channel at the head of a grant-order FIFO.
module roce_tx_chan_arbiter #(
    parameter int ROCE_EN   = 1,
    parameter int N_CH      = 4,
    parameter int META_W    = 160,
    parameter int DATA_W    = 512,
    parameter int ORD_DEPTH = 16
) (
    input  logic                       net_clk,
    input  logic                       net_rst,
    input  logic [N_CH-1:0]            s_meta_valid,
    output logic [N_CH-1:0]            s_meta_ready,
    input  logic [N_CH*META_W-1:0]     s_meta_data,
    input  logic [N_CH-1:0]            s_data_valid,
    output logic [N_CH-1:0]            s_data_ready,
    input  logic [N_CH*DATA_W-1:0]     s_data_data,
    input  logic [N_CH*DATA_W/8-1:0]   s_data_keep,
    input  logic [N_CH-1:0]            s_data_last,
    output logic                       m_meta_valid,
    input  logic                       m_meta_ready,
    output logic [META_W-1:0]          m_meta_data,
    output logic                       m_data_valid,
    input  logic                       m_data_ready,
    output logic [DATA_W-1:0]          m_data_data,
    output logic [DATA_W/8-1:0]        m_data_keep,
    output logic                       m_data_last,
    output logic [31:0]                meta_grant_count,
    output logic                       ord_fifo_full
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW     = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
    localparam int CNT_W  = AW + 1;
    localparam bit EN     = (ROCE_EN != 0);

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  winner;
    logic [CH_W-1:0]  cand;
    logic             any_req;
    logic             meta_free;
    logic             grant;

    logic [CH_W-1:0]  ord_mem [ORD_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] ord_cnt;
    logic [CNT_W-1:0] ord_cnt_nxt;
    logic             ord_ne;
    logic [CH_W-1:0]  head;
    logic             push;
    logic             pop;

    // Round-robin search starts one past the last winner and wraps mod N_CH.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(rr_ptr) + k) % N_CH);
            if (!any_req && s_meta_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    assign meta_free = !m_meta_valid || m_meta_ready;
    assign grant     = EN && !net_rst && meta_free && !ord_fifo_full && any_req;
    assign push      = grant;

    always_comb begin
        s_meta_ready = '0;
        if (grant) s_meta_ready[winner] = 1'b1;
    end

    assign ord_ne = (ord_cnt != '0);
    assign head   = ord_mem[rd_ptr];

    // Payload is only ever taken from the channel whose meta sits at the FIFO head.
    always_comb begin
        m_data_valid = EN && ord_ne && s_data_valid[head];
        m_data_data  = s_data_data[int'(head)*DATA_W +: DATA_W];
        m_data_keep  = s_data_keep[int'(head)*KEEP_W +: KEEP_W];
        m_data_last  = s_data_last[head];
        s_data_ready = '0;
        if (EN && !net_rst && ord_ne && m_data_ready) s_data_ready[head] = 1'b1;
    end

    assign pop = m_data_valid && m_data_ready && m_data_last;

    always_comb begin
        ord_cnt_nxt = ord_cnt;
        case ({push, pop})
            2'b10:   ord_cnt_nxt = ord_cnt + CNT_W'(1);
            2'b01:   ord_cnt_nxt = ord_cnt - CNT_W'(1);
            default: ord_cnt_nxt = ord_cnt;
        endcase
    end

    // Control state: grant register, RR pointer, order-FIFO pointers and status.
    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            m_meta_valid     <= 1'b0;
            rr_ptr           <= CH_W'(N_CH - 1);
            meta_grant_count <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            ord_cnt          <= '0;
            ord_fifo_full    <= 1'b0;
        end else begin
            if (grant)             m_meta_valid <= 1'b1;
            else if (m_meta_ready) m_meta_valid <= 1'b0;
            if (grant) begin
                rr_ptr           <= winner;
                meta_grant_count <= meta_grant_count + 32'd1;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            ord_cnt       <= ord_cnt_nxt;
            ord_fifo_full <= (ord_cnt_nxt == CNT_W'(ORD_DEPTH));
        end
    end

    // Datapath storage carries no reset; validity is tracked by the control state above.
    always_ff @(posedge net_clk) begin
        if (grant) m_meta_data <= s_meta_data[int'(winner)*META_W +: META_W];
        if (push)  ord_mem[wr_ptr] <= winner;
    end

endmodule

// File: tb/tb_roce_tx_chan_arbiter.sv
// Directed bench for roce_tx_chan_arbiter: 4 channels, 32-bit meta and payload, 16-deep order FIFO.
module tb_roce_tx_chan_arbiter;

    localparam int N_CH = 4;
    localparam int MW   = 32;
    localparam int DW   = 32;
    localparam int KW   = DW / 8;

    logic                 clk;
    logic                 net_rst;
    logic [N_CH-1:0]      s_meta_valid;
    logic [N_CH-1:0]      s_meta_ready;
    logic [N_CH*MW-1:0]   s_meta_data;
    logic [N_CH-1:0]      s_data_valid;
    logic [N_CH-1:0]      s_data_ready;
    logic [N_CH*DW-1:0]   s_data_data;
    logic [N_CH*KW-1:0]   s_data_keep;
    logic [N_CH-1:0]      s_data_last;
    logic                 m_meta_valid;
    logic                 m_meta_ready;
    logic [MW-1:0]        m_meta_data;
    logic                 m_data_valid;
    logic                 m_data_ready;
    logic [DW-1:0]        m_data_data;
    logic [KW-1:0]        m_data_keep;
    logic                 m_data_last;
    logic [31:0]          meta_grant_count;
    logic                 ord_fifo_full;

    int n_vec = 0;
    int n_err = 0;

    roce_tx_chan_arbiter #(
        .ROCE_EN(1), .N_CH(N_CH), .META_W(MW), .DATA_W(DW), .ORD_DEPTH(16)
    ) dut (
        .net_clk(clk), .net_rst(net_rst),
        .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
        .s_data_keep(s_data_keep), .s_data_last(s_data_last),
        .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
        .m_data_keep(m_data_keep), .m_data_last(m_data_last),
        .meta_grant_count(meta_grant_count), .ord_fifo_full(ord_fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_meta_valid = '0; s_meta_data = '0;
        s_data_valid = '0; s_data_data = '0; s_data_keep = '0; s_data_last = '0;
        m_meta_ready = 1'b0; m_data_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        net_rst = 1'b1;
        tick(); tick();
        net_rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        net_rst = 1'b1;
        s_meta_valid = 4'hF;
        tick(); tick();
        n_vec++; if (s_meta_ready !== 4'b0000) begin n_err++; $display("FAIL rst_meta_ready: got %b want 0000", s_meta_ready); end
        n_vec++; if (s_data_ready !== 4'b0000) begin n_err++; $display("FAIL rst_data_ready: got %b want 0000", s_data_ready); end
        n_vec++; if (m_meta_valid !== 1'b0) begin n_err++; $display("FAIL rst_meta_valid: got %b want 0", m_meta_valid); end
        n_vec++; if (m_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_data_valid: got %b want 0", m_data_valid); end
        n_vec++; if (meta_grant_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", meta_grant_count); end
        n_vec++; if (ord_fifo_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", ord_fifo_full); end
        net_rst = 1'b0;
        s_meta_valid = '0;
    endtask

    task automatic test_single();
        logic [31:0] exp_d;
        do_reset();
        m_meta_ready = 1'b1; m_data_ready = 1'b1;
        s_meta_valid[0] = 1'b1; s_meta_data[31:0] = 32'hA000_0001;
        #1;
        n_vec++; if (s_meta_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", s_meta_ready); end
        tick();
        s_meta_valid = '0;
        n_vec++; if (m_meta_valid !== 1'b1) begin n_err++; $display("FAIL single_mvalid: got %b want 1", m_meta_valid); end
        n_vec++; if (m_meta_data !== 32'hA000_0001) begin n_err++; $display("FAIL single_mdata: got %h want a0000001", m_meta_data); end
        n_vec++; if (meta_grant_count !== 32'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", meta_grant_count); end
        for (int b = 0; b < 3; b++) begin
            exp_d = 32'hD000_0000 + 32'(b);
            s_data_valid[0] = 1'b1; s_data_data[31:0] = exp_d; s_data_keep[3:0] = 4'h7; s_data_last[0] = (b == 2);
            #1;
            n_vec++; if (m_data_valid !== 1'b1 || m_data_data !== exp_d || m_data_keep !== 4'h7 || m_data_last !== (b == 2))
                begin n_err++; $display("FAIL single_beat%0d: got v=%b d=%h k=%h l=%b want v=1 d=%h k=7 l=%b", b, m_data_valid, m_data_data, m_data_keep, m_data_last, exp_d, (b == 2)); end
            n_vec++; if (s_data_ready !== 4'b0001) begin n_err++; $display("FAIL single_dready%0d: got %b want 0001", b, s_data_ready); end
            tick();
        end
        s_data_data[31:0] = 32'hDEAD_0000; s_data_last[0] = 1'b0;
        #1;
        n_vec++; if (m_data_valid !== 1'b0) begin n_err++; $display("FAIL single_after_pop: got %b want 0", m_data_valid); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_r;
        logic [31:0] exp_d;
        int beat [N_CH];
        int msg [N_CH];
        int expch;
        do_reset();
        m_meta_ready = 1'b1; m_data_ready = 1'b1;
        for (int c = 0; c < N_CH; c++) s_meta_data[c*MW +: MW] = 32'hC0DE_0000 + 32'(c);
        s_meta_valid = 4'hF;
        for (int g = 0; g < 8; g++) begin
            exp_r = 4'b0001 << (g % 4);
            #1;
            n_vec++; if (s_meta_ready !== exp_r) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", g, s_meta_ready, exp_r); end
            tick();
            n_vec++; if (m_meta_data !== 32'hC0DE_0000 + 32'(g % 4)) begin n_err++; $display("FAIL rr_mdata%0d: got %h want %h", g, m_meta_data, 32'hC0DE_0000 + 32'(g % 4)); end
        end
        s_meta_valid = '0;
        n_vec++; if (meta_grant_count !== 32'd8) begin n_err++; $display("FAIL rr_count: got %0d want 8", meta_grant_count); end
        for (int c = 0; c < N_CH; c++) begin beat[c] = 0; msg[c] = 0; end
        for (int cyc = 0; cyc < 16; cyc++) begin
            expch = (cyc / 2) % 4;
            for (int c = 0; c < N_CH; c++) begin
                s_data_data[c*DW +: DW] = 32'(c*256 + msg[c]*16 + beat[c]);
                s_data_last[c] = (beat[c] == 1);
                s_data_keep[c*KW +: KW] = 4'hF;
            end
            s_data_valid = 4'hF;
            exp_d = 32'(expch*256 + (cyc/8)*16 + (cyc%2));
            exp_r = 4'b0001 << expch;
            #1;
            n_vec++; if (m_data_valid !== 1'b1 || m_data_data !== exp_d || m_data_last !== (cyc % 2 == 1) || s_data_ready !== exp_r)
                begin n_err++; $display("FAIL rr_payload%0d: got v=%b d=%h l=%b r=%b want v=1 d=%h l=%b r=%b", cyc, m_data_valid, m_data_data, m_data_last, s_data_ready, exp_d, (cyc % 2 == 1), exp_r); end
            tick();
            beat[expch]++;
            if (beat[expch] == 2) begin beat[expch] = 0; msg[expch]++; end
        end
        #1;
        n_vec++; if (m_data_valid !== 1'b0) begin n_err++; $display("FAIL rr_drained: got %b want 0", m_data_valid); end
        clear_inputs();
    endtask

    task automatic test_meta_backpressure();
        do_reset();
        s_meta_valid[2] = 1'b1; s_meta_data[64 +: 32] = 32'h2222_0000;
        #1;
        n_vec++; if (s_meta_ready !== 4'b0100) begin n_err++; $display("FAIL bp_first: got %b want 0100", s_meta_ready); end
        tick();
        for (int i = 0; i < 5; i++) begin
            s_meta_data[64 +: 32] = 32'h2222_0001 + 32'(i);
            #1;
            n_vec++; if (s_meta_ready !== 4'b0000 || m_meta_valid !== 1'b1 || m_meta_data !== 32'h2222_0000)
                begin n_err++; $display("FAIL bp_hold%0d: got r=%b v=%b d=%h want r=0000 v=1 d=22220000", i, s_meta_ready, m_meta_valid, m_meta_data); end
            tick();
        end
        n_vec++; if (meta_grant_count !== 32'd1) begin n_err++; $display("FAIL bp_count: got %0d want 1", meta_grant_count); end
        m_meta_ready = 1'b1;
        #1;
        n_vec++; if (s_meta_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release: got %b want 0100", s_meta_ready); end
        tick();
        s_meta_valid = '0;
        n_vec++; if (m_meta_data !== 32'h2222_0005 || meta_grant_count !== 32'd2)
            begin n_err++; $display("FAIL bp_second: got d=%h c=%0d want d=22220005 c=2", m_meta_data, meta_grant_count); end
        clear_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        m_meta_ready = 1'b1;
        s_meta_valid[0] = 1'b1; s_meta_data[31:0] = 32'h0F0F_0000;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_vec++; if (s_meta_ready !== 4'b0001) begin n_err++; $display("FAIL full_grant%0d: got %b want 0001", i, s_meta_ready); end
            tick();
        end
        n_vec++; if (ord_fifo_full !== 1'b1 || meta_grant_count !== 32'd16)
            begin n_err++; $display("FAIL full_flag: got f=%b c=%0d want f=1 c=16", ord_fifo_full, meta_grant_count); end
        #1;
        n_vec++; if (s_meta_ready !== 4'b0000) begin n_err++; $display("FAIL full_block: got %b want 0000", s_meta_ready); end
        tick();
        n_vec++; if (meta_grant_count !== 32'd16) begin n_err++; $display("FAIL full_count: got %0d want 16", meta_grant_count); end
        s_data_valid[0] = 1'b1; s_data_last[0] = 1'b1; s_data_data[31:0] = 32'h0F0F_D000; m_data_ready = 1'b1;
        #1;
        n_vec++; if (m_data_valid !== 1'b1 || s_meta_ready !== 4'b0000)
            begin n_err++; $display("FAIL full_pop: got v=%b r=%b want v=1 r=0000", m_data_valid, s_meta_ready); end
        tick();
        s_data_valid = '0; m_data_ready = 1'b0;
        n_vec++; if (ord_fifo_full !== 1'b0) begin n_err++; $display("FAIL full_clear: got %b want 0", ord_fifo_full); end
        #1;
        n_vec++; if (s_meta_ready !== 4'b0001) begin n_err++; $display("FAIL full_regrant: got %b want 0001", s_meta_ready); end
        tick();
        s_meta_valid = '0;
        n_vec++; if (meta_grant_count !== 32'd17 || ord_fifo_full !== 1'b1)
            begin n_err++; $display("FAIL full_refill: got c=%0d f=%b want c=17 f=1", meta_grant_count, ord_fifo_full); end
        clear_inputs();
    endtask

    task automatic test_head_block();
        do_reset();
        m_meta_ready = 1'b1; m_data_ready = 1'b1;
        s_data_valid[1] = 1'b1; s_data_data[32 +: 32] = 32'h1111_AAAA; s_data_last[1] = 1'b1; s_data_keep = '1;
        s_meta_valid[3] = 1'b1; s_meta_data[96 +: 32] = 32'h3333_0000;
        #1;
        n_vec++; if (m_data_valid !== 1'b0 || s_data_ready !== 4'b0000 || s_meta_ready !== 4'b1000)
            begin n_err++; $display("FAIL hb_empty: got v=%b dr=%b mr=%b want v=0 dr=0000 mr=1000", m_data_valid, s_data_ready, s_meta_ready); end
        tick();
        s_meta_valid[3] = 1'b0;
        s_data_valid[3] = 1'b1; s_data_data[96 +: 32] = 32'h3333_D000; s_data_last[3] = 1'b0;
        s_meta_valid[1] = 1'b1; s_meta_data[32 +: 32] = 32'h1111_0000;
        #1;
        n_vec++; if (m_data_data !== 32'h3333_D000 || s_data_ready !== 4'b1000 || s_meta_ready !== 4'b0010)
            begin n_err++; $display("FAIL hb_ch3b0: got d=%h dr=%b mr=%b want d=3333d000 dr=1000 mr=0010", m_data_data, s_data_ready, s_meta_ready); end
        tick();
        s_meta_valid[1] = 1'b0;
        s_data_data[96 +: 32] = 32'h3333_D001; s_data_last[3] = 1'b1;
        #1;
        n_vec++; if (m_data_data !== 32'h3333_D001 || m_data_last !== 1'b1 || s_data_ready !== 4'b1000)
            begin n_err++; $display("FAIL hb_ch3b1: got d=%h l=%b dr=%b want d=3333d001 l=1 dr=1000", m_data_data, m_data_last, s_data_ready); end
        tick();
        s_data_valid[3] = 1'b0; s_data_last[3] = 1'b0;
        #1;
        n_vec++; if (m_data_valid !== 1'b1 || m_data_data !== 32'h1111_AAAA || s_data_ready !== 4'b0010)
            begin n_err++; $display("FAIL hb_ch1: got v=%b d=%h dr=%b want v=1 d=1111aaaa dr=0010", m_data_valid, m_data_data, s_data_ready); end
        tick();
        s_data_data[32 +: 32] = 32'h1111_BBBB;
        #1;
        n_vec++; if (m_data_valid !== 1'b0) begin n_err++; $display("FAIL hb_nodup: got %b want 0", m_data_valid); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_meta_ready = 1'b1; m_data_ready = 1'b1;
        s_meta_valid[0] = 1'b1; s_meta_data[31:0] = 32'h5050_0000;
        tick();
        s_meta_valid = '0;
        for (int b = 0; b < 2; b++) begin
            s_data_valid[0] = 1'b1; s_data_data[31:0] = 32'h5000_0000 + 32'(b); s_data_last[0] = 1'b0;
            tick();
        end
        s_data_data[31:0] = 32'h5000_0002;
        s_meta_valid[2] = 1'b1;
        net_rst = 1'b1;
        tick();
        n_vec++; if (m_meta_valid !== 1'b0 || m_data_valid !== 1'b0 || s_meta_ready !== 4'b0000 || s_data_ready !== 4'b0000 || meta_grant_count !== 32'd0)
            begin n_err++; $display("FAIL midrst: got mv=%b dv=%b mr=%b dr=%b c=%0d want all 0", m_meta_valid, m_data_valid, s_meta_ready, s_data_ready, meta_grant_count); end
        net_rst = 1'b0;
        clear_inputs();
        m_meta_ready = 1'b1; m_data_ready = 1'b1;
        s_meta_valid = 4'b0101; s_meta_data[31:0] = 32'h6060_0000; s_meta_data[64 +: 32] = 32'h6262_0000;
        #1;
        n_vec++; if (s_meta_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_fresh: got %b want 0001", s_meta_ready); end
        tick();
        s_meta_valid = '0;
        n_vec++; if (meta_grant_count !== 32'd1 || m_meta_data !== 32'h6060_0000)
            begin n_err++; $display("FAIL midrst_after: got c=%0d d=%h want c=1 d=60600000", meta_grant_count, m_meta_data); end
        clear_inputs();
    endtask

    initial begin
        net_rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_meta_backpressure();
        test_fifo_full();
        test_head_block();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
